multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multicycle control sequencer for the 16-bit datapath: 16-entry register file, ALU with flags, data memory, 6-bit PC.
- Replaces the single-cycle combinational control unit with a Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Steps an iterative 16-cycle shift-add multiplier for the R3 = R1*R2 program.
- Waits on a ready handshake from data memory.
- Sits between instruction memory/IR and every datapath enable, mux select and ALU op.

Parameters:
- MUL_CYCLES, 16, number of MULW cycles; one per multiplier bit, legal range 1..63.
- OPW, 4, opcode width, taken from instruction[15:12].

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  input  4  instruction[15:12] from instruction memory, valid while in FETCH
- neq  input  1  ALU not-equal flag, valid in EXEC
- mem_ready  input  1  data memory completion, sampled in MEM
- pc_write  output  1  load PC
- pc_src  output  1  0 = PC+1, 1 = branch target
- ir_write  output  1  latch instruction register
- reg_write  output  1  register file load
- reg_dst  output  1  1 = write address instruction[3:0], 0 = instruction[7:4]
- alu_src  output  1  0 = register B, 1 = sign-extended immediate
- alu_op  output  3  ALU function select
- mem_req  output  1  data memory access request
- mem_write  output  1  qualifies mem_req as a write
- mem_to_reg  output  1  1 = writeback data from memory
- mul_load  output  1  one-cycle pulse: load multiplier operands, clear accumulator
- mul_en  output  1  multiplier step enable
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- halted  output  1  FSM in HALT
- state  output  3  current state encoding, for debug

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT: R-type.
  - 5 MUL, 8 LW, 9 SW, A BNE, F HALT.
  - All other values undefined.
- Opcode register: captured on the clock edge leaving FETCH. All decode after FETCH uses the latched copy, never the live input.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MULW=4, MEM=5, WB=6, HALT=7.
- Outputs are a pure function of state and latched opcode (Moore). Every strobe not listed for a state is 0.
- Reset (rst_n=0, asynchronous, any state, including mid-MULW or mid-MEM):
  - state=IDLE; opcode register=0; mul counter=0.
  - All outputs 0, with state=0 and halted=0.
  - Takes effect without waiting for a clock edge.
- IDLE: run=1 -> FETCH, else stay.
- FETCH:
  - ir_write=1, pc_write=1, pc_src=0.
  - -> DECODE.
- DECODE:
  - Defined opcode other than HALT or MUL -> EXEC.
  - MUL -> MULW; mul_load=1 in this state; counter cleared.
  - HALT -> HALT.
  - Undefined opcode: illegal_op=1, treated as NOP, -> boundary.
- EXEC:
  - alu_op = latched opcode[2:0] for R-type; alu_op=0 (add) for LW/SW with alu_src=1; alu_op=1 (sub) for BNE.
  - R-type -> WB; LW/SW -> MEM.
  - BNE: if neq=1 then pc_write=1, pc_src=1. -> boundary.
- MULW:
  - mul_en=1; counter increments each cycle.
  - When counter=MUL_CYCLES-1 -> WB. Exactly MUL_CYCLES cycles in MULW.
- MEM:
  - mem_req=1; mem_write=1 for SW, 0 for LW.
  - Held until mem_ready=1 is sampled. mem_ready already 1 on entry gives a 1-cycle MEM.
  - On mem_ready: LW -> WB; SW -> boundary.
  - mem_ready while not in MEM is ignored.
- WB:
  - reg_write=1; reg_dst=1.
  - mem_to_reg=1 for LW, 0 otherwise.
  - -> boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. run is ignored mid-instruction.
- HALT: halted=1; exit only via reset.
- Cycle counts, FETCH through last state:
  - R-type 4.
  - LW 5 + (MEM wait cycles − 1).
  - SW 4 + (MEM wait cycles − 1).
  - BNE 3.
  - MUL 3 + MUL_CYCLES.
  - Undefined 2.
  - HALT 2, then holds.
- PC width and wrap are owned by the datapath; the FSM never inspects PC.

Test Plan:
- Reset, then run=1, ADD (opcode 0) -> states 1,2,3,6,1. reg_write high only in WB, alu_op=000 in EXEC, pc_write only in FETCH.
- LW with mem_ready held low 3 cycles after MEM entry -> mem_req=1, mem_write=0 for 4 cycles, then WB with mem_to_reg=1 and reg_write=1. SW with mem_ready=1 -> 1-cycle MEM, mem_write=1, no WB, next state FETCH.
- BNE with neq=1 -> pc_write=1 and pc_src=1 in EXEC. BNE with neq=0 -> pc_write=0 in EXEC. Both return to FETCH after 3 cycles.
- MUL, MUL_CYCLES=16 -> mul_load pulse in DECODE, mul_en high exactly 16 cycles, then WB with reg_write=1. Total 19 cycles.
- Opcode 0xC -> illegal_op one-cycle pulse in DECODE, back to FETCH. Opcode 0xF -> halted=1 indefinitely, ignoring run and opcode.
- run dropped mid-MULW -> instruction completes through WB, then IDLE. rst_n pulled low mid-MEM, between clock edges -> state=0 and all strobes 0 immediately. After release with run=1 -> FETCH on the next edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: Moore FSM driving the datapath enables, mux selects and ALU op
// through fetch, decode, execute, memory and writeback, with an iterative multiplier step counter.
module multicycle_ctrl_fsm #(
    parameter int MUL_CYCLES = 16,
    parameter int OPW        = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           neq,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_src,
    output logic           ir_write,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           alu_src,
    output logic [2:0]     alu_op,
    output logic           mem_req,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           mul_load,
    output logic           mul_en,
    output logic           illegal_op,
    output logic           halted,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MULW   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_MUL  = OPW'(5);
    localparam logic [OPW-1:0] OP_LW   = OPW'(8);
    localparam logic [OPW-1:0] OP_SW   = OPW'(9);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(10);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);
    localparam logic [5:0]     MUL_LAST = 6'(MUL_CYCLES - 1);

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [5:0]     mul_cnt_q, mul_cnt_d;

    logic is_rtype, is_mul, is_lw, is_sw, is_bne, is_halt, is_defined;
    state_t boundary;

    // Decode is driven only from the copy latched on leaving FETCH.
    assign is_rtype   = (opcode_q < OPW'(5));
    assign is_mul     = (opcode_q == OP_MUL);
    assign is_lw      = (opcode_q == OP_LW);
    assign is_sw      = (opcode_q == OP_SW);
    assign is_bne     = (opcode_q == OP_BNE);
    assign is_halt    = (opcode_q == OP_HALT);
    assign is_defined = is_rtype | is_mul | is_lw | is_sw | is_bne | is_halt;
    assign boundary   = run ? S_FETCH : S_IDLE;
    assign state      = state_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        opcode_d   = opcode_q;
        mul_cnt_d  = mul_cnt_q;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        mul_load   = 1'b0;
        mul_en     = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                opcode_d = opcode;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_mul) begin
                    mul_load  = 1'b1;
                    mul_cnt_d = 6'd0;
                    state_d   = S_MULW;
                end else if (is_defined) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = boundary;
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    alu_op  = opcode_q[2:0];
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else begin
                    alu_op = 3'd1;
                    if (is_bne && neq) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    state_d = boundary;
                end
            end
            S_MULW: begin
                mul_en = 1'b1;
                if (mul_cnt_q == MUL_LAST) begin
                    state_d = S_WB;
                end else begin
                    mul_cnt_d = mul_cnt_q + 6'd1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = is_sw;
                if (mem_ready) state_d = is_lw ? S_WB : boundary;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = is_lw;
                state_d    = boundary;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is asynchronous so the strobes drop immediately, even between clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            mul_cnt_q <= 6'd0;
        end else begin
            // NOTE: non-blocking updates keep all flops sampling the same pre-edge values.
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Table-driven bench for multicycle_ctrl_fsm: per-cycle vectors of inputs and expected
// state/strobes, plus hand-written reset and multiplier-length sequences.
module tb_multicycle_ctrl_fsm;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                           S_MULW = 3'd4, S_MEM = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

    // Packed strobe word: {pc_write,pc_src,ir_write,reg_write,reg_dst,alu_src,alu_op,
    //                      mem_req,mem_write,mem_to_reg,mul_load,mul_en,illegal_op,halted}
    localparam logic [15:0] PCW = 16'h8000, PCS = 16'h4000, IRW = 16'h2000, RGW = 16'h1000,
                            RGD = 16'h0800, ALS = 16'h0400, ALU1 = 16'h0080, ALU2 = 16'h0100,
                            ALU3 = 16'h0180, ALU4 = 16'h0200, MRQ = 16'h0040, MWR = 16'h0020,
                            M2R = 16'h0010, MLD = 16'h0008, MEN = 16'h0004, ILL = 16'h0002,
                            HLT = 16'h0001;

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic        neq;
        logic        mrdy;
        logic [2:0]  st;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, run, neq, mem_ready;
    logic [3:0] opcode;
    logic pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src;
    logic [2:0] alu_op, state;
    logic mem_req, mem_write, mem_to_reg, mul_load, mul_en, illegal_op, halted;
    logic [15:0] outs;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MUL_CYCLES(16), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .neq(neq), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .mem_req(mem_req),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .mul_load(mul_load), .mul_en(mul_en),
        .illegal_op(illegal_op), .halted(halted), .state(state)
    );

    assign outs = {pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src, alu_op,
                   mem_req, mem_write, mem_to_reg, mul_load, mul_en, illegal_op, halted};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic void v(input logic r, input logic [3:0] op, input logic nq,
                              input logic mr, input logic [2:0] st, input logic [15:0] exp);
        vec_t e;
        e.run = r; e.op = op; e.neq = nq; e.mrdy = mr; e.st = st; e.exp = exp;
        vecs.push_back(e);
    endfunction

    int  mul_cnt;
    bit  done;

    initial begin
        // Program: live opcode is driven with junk outside FETCH to prove decode uses the latch.
        v(0, 4'h0, 0, 0, S_IDLE, 16'h0);
        v(0, 4'h0, 0, 1, S_IDLE, 16'h0);
        v(1, 4'h0, 0, 0, S_IDLE, 16'h0);
        // ADD
        v(1, 4'h0, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'hF, 0, 1, S_DEC,   16'h0);
        v(1, 4'hF, 1, 1, S_EXEC,  16'h0);
        v(1, 4'hF, 0, 1, S_WB,    RGW | RGD);
        // SUB
        v(1, 4'h1, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   16'h0);
        v(1, 4'h0, 0, 0, S_EXEC,  ALU1);
        v(1, 4'h0, 0, 0, S_WB,    RGW | RGD);
        // AND
        v(1, 4'h2, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h5, 0, 0, S_DEC,   16'h0);
        v(1, 4'h5, 0, 0, S_EXEC,  ALU2);
        v(1, 4'h5, 0, 0, S_WB,    RGW | RGD);
        // OR with run dropped mid-instruction (ignored)
        v(1, 4'h3, 0, 0, S_FETCH, PCW | IRW);
        v(0, 4'h8, 0, 0, S_DEC,   16'h0);
        v(0, 4'h8, 0, 0, S_EXEC,  ALU3);
        v(1, 4'h8, 0, 0, S_WB,    RGW | RGD);
        // SLT
        v(1, 4'h4, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h9, 0, 0, S_DEC,   16'h0);
        v(1, 4'h9, 0, 0, S_EXEC,  ALU4);
        v(1, 4'h9, 0, 0, S_WB,    RGW | RGD);
        // LW with three wait cycles
        v(1, 4'h8, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   16'h0);
        v(1, 4'h0, 0, 0, S_EXEC,  ALS);
        v(1, 4'h0, 0, 0, S_MEM,   MRQ);
        v(1, 4'h0, 0, 0, S_MEM,   MRQ);
        v(1, 4'h0, 0, 0, S_MEM,   MRQ);
        v(1, 4'h0, 0, 1, S_MEM,   MRQ);
        v(1, 4'h0, 0, 0, S_WB,    RGW | RGD | M2R);
        // SW with ready on entry
        v(1, 4'h9, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   16'h0);
        v(1, 4'h0, 0, 0, S_EXEC,  ALS);
        v(1, 4'h0, 0, 1, S_MEM,   MRQ | MWR);
        // BNE taken, then not taken
        v(1, 4'hA, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   16'h0);
        v(1, 4'h0, 1, 0, S_EXEC,  PCW | PCS | ALU1);
        v(1, 4'hA, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 1, 0, S_DEC,   16'h0);
        v(1, 4'h0, 0, 0, S_EXEC,  ALU1);
        // Undefined 0xC, then 0x6 with run low at the boundary
        v(1, 4'hC, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   ILL);
        v(1, 4'h6, 0, 0, S_FETCH, PCW | IRW);
        v(0, 4'h0, 0, 0, S_DEC,   ILL);
        v(0, 4'h0, 0, 0, S_IDLE,  16'h0);
        v(1, 4'h0, 0, 0, S_IDLE,  16'h0);
        // MUL: 16 MULW cycles, run dropped mid-way, ends in IDLE
        v(1, 4'h5, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   MLD);
        for (int k = 0; k < 16; k++) v((k < 4), 4'h0, 0, 1, S_MULW, MEN);
        v(0, 4'h0, 0, 0, S_WB,    RGW | RGD);
        v(0, 4'h0, 0, 0, S_IDLE,  16'h0);
        v(1, 4'h0, 0, 0, S_IDLE,  16'h0);
        // HALT holds regardless of run and opcode
        v(1, 4'hF, 0, 0, S_FETCH, PCW | IRW);
        v(1, 4'h0, 0, 0, S_DEC,   16'h0);
        for (int k = 0; k < 6; k++) v(k[0], 4'(k), 0, 1, S_HALT, HLT);

        rst_n = 1'b0; run = 1'b0; opcode = 4'h0; neq = 1'b0; mem_ready = 1'b0;
        #1 check("reset state", 32'(state), 32'(S_IDLE));
        check("reset strobes", 32'(outs), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; opcode = vecs[i].op; neq = vecs[i].neq; mem_ready = vecs[i].mrdy;
            #1;
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d strobes", i), 32'(outs), 32'(vecs[i].exp));
        end

        // Reset releases HALT; then LW is reset asynchronously mid-MEM.
        @(negedge clk); rst_n = 1'b0; run = 1'b0;
        #1 check("reset from halt", 32'(state), 32'(S_IDLE));
        @(negedge clk); rst_n = 1'b1; run = 1'b1; opcode = 4'h8; mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("lw in mem", 32'(state), 32'(S_MEM));
        #2 rst_n = 1'b0;
        #1 check("async reset mid-mem state", 32'(state), 32'(S_IDLE));
        check("async reset mid-mem strobes", 32'(outs), 32'h0);
        @(negedge clk); rst_n = 1'b1; run = 1'b1; opcode = 4'h5;
        #1 check("post-reset idle", 32'(state), 32'(S_IDLE));
        @(posedge clk); #1 check("post-reset fetch", 32'(state), 32'(S_FETCH));

        // Measure MULW length with a bounded wait.
        mul_cnt = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (state == S_MULW) mul_cnt++;
            else if (mul_cnt > 0) done = 1'b1;
        end
        check("mul completed", 32'(done), 32'd1);
        check("mul cycle count", 32'(mul_cnt), 32'd16);
        check("mul ends in wb", 32'(state), 32'(S_WB));

        // Second MUL, reset asynchronously mid-MULW.
        repeat (3) @(negedge clk);
        #1 check("second mul in mulw", 32'(state), 32'(S_MULW));
        #2 rst_n = 1'b0;
        #1 check("async reset mid-mulw state", 32'(state), 32'(S_IDLE));
        check("async reset mid-mulw strobes", 32'(outs), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
